// File: rtl/das_pkg.sv
// rtl/das_pkg.sv - width helpers shared by the delay-and-sum MAC pipeline
package das_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int prod_w(input int din_w, input int coef_w);
      return din_w + coef_w;
   endfunction

   function automatic int sum_w(input int din_w, input int coef_w, input int num_ch);
      return prod_w(din_w, coef_w) + clog2(num_ch);
   endfunction

   function automatic int acc_w(input int din_w, input int coef_w, input int num_ch,
                                input int guard);
      return sum_w(din_w, coef_w, num_ch) + guard;
   endfunction

endpackage

// File: rtl/das_sat_round.sv
// rtl/das_sat_round.sv - round-half-up arithmetic shift followed by signed saturation
module das_sat_round #(
   parameter int IN_W  = 37,
   parameter int OUT_W = 16,
   parameter int SHIFT = 10
) (
   input  logic [IN_W-1:0]  i_acc,
   output logic [OUT_W-1:0] o_dout,
   output logic             o_clamp
);

   // One extra MSB so adding the rounding constant can never wrap.
   localparam int EXT_W  = IN_W + 1;
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [EXT_W-1:0] RND =
      (SHIFT > 0) ? ({{(EXT_W-1){1'b0}}, 1'b1} << RND_SH) : '0;
   localparam logic signed [EXT_W-1:0] MAXV = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] MINV = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [EXT_W-1:0] w_biased;
   logic signed [EXT_W-1:0] w_shifted;

   always_comb begin
      w_biased  = $signed({i_acc[IN_W-1], i_acc}) + $signed(RND);
      w_shifted = w_biased >>> SHIFT;
      o_clamp   = 1'b0;
      o_dout    = w_shifted[OUT_W-1:0];
      if (w_shifted > MAXV) begin
         o_dout  = MAXV[OUT_W-1:0];
         o_clamp = 1'b1;
      end else if (w_shifted < MINV) begin
         o_dout  = MINV[OUT_W-1:0];
         o_clamp = 1'b1;
      end
   end

endmodule

// File: rtl/das_mac_pipe.sv
// rtl/das_mac_pipe.sv - multi-channel signed weighted-sum accumulate pipeline
// input reg -> MUL_STAGES product regs -> adder-tree reg -> accumulator/output reg
module das_mac_pipe import das_pkg::*; #(
   parameter int NUM_CH     = 4,
   parameter int DIN_W      = 16,
   parameter int COEF_W     = 11,
   parameter int MUL_STAGES = 2,
   parameter int ACC_GUARD  = 8,
   parameter int SHIFT      = 10,
   parameter int OUT_W      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ce,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DIN_W-1:0]  din,
   input  logic [NUM_CH*COEF_W-1:0] coef,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         dout,
   output logic                     ovf
);

   localparam int PROD_W = prod_w(DIN_W, COEF_W);
   localparam int SUM_W  = sum_w(DIN_W, COEF_W, NUM_CH);
   localparam int ACC_W  = acc_w(DIN_W, COEF_W, NUM_CH, ACC_GUARD);

   logic                     w_adv;
   logic [NUM_CH*DIN_W-1:0]  r_din;
   logic [NUM_CH*COEF_W-1:0] r_coef;
   logic                     r_in_valid, r_in_last;
   logic [MUL_STAGES-1:0]    r_m_valid, r_m_last;
   logic signed [PROD_W-1:0] w_prod_q [NUM_CH];
   logic signed [SUM_W-1:0]  w_sum, r_sum;
   logic                     r_t_valid, r_t_last;
   logic signed [ACC_W-1:0]  r_acc, w_acc_base, w_acc_n;
   logic                     r_first;
   logic [OUT_W-1:0]         w_dout;
   logic                     w_clamp;

   // The whole pipe advances as one; a held result blocks everything behind it.
   assign w_adv    = ce & (~out_valid | out_ready);
   assign in_ready = w_adv;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_din      <= '0;
         r_coef     <= '0;
         r_in_valid <= 1'b0;
         r_in_last  <= 1'b0;
         r_m_valid  <= '0;
         r_m_last   <= '0;
      end else if (w_adv) begin
         r_din        <= din;
         r_coef       <= coef;
         r_in_valid   <= in_valid;
         r_in_last    <= in_valid & in_last;
         r_m_valid[0] <= r_in_valid;
         r_m_last[0]  <= r_in_last;
         for (int s = 1; s < MUL_STAGES; s++) begin
            r_m_valid[s] <= r_m_valid[s-1];
            r_m_last[s]  <= r_m_last[s-1];
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic signed [PROD_W-1:0] w_prod;
      logic signed [PROD_W-1:0] r_pipe [MUL_STAGES];

      assign w_prod = PROD_W'($signed(r_din[c*DIN_W +: DIN_W])) *
                      PROD_W'($signed(r_coef[c*COEF_W +: COEF_W]));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int s = 0; s < MUL_STAGES; s++) r_pipe[s] <= '0;
         end else if (w_adv) begin
            r_pipe[0] <= w_prod;
            for (int s = 1; s < MUL_STAGES; s++) r_pipe[s] <= r_pipe[s-1];
         end
      end

      assign w_prod_q[c] = r_pipe[MUL_STAGES-1];
   end

   always_comb begin
      w_sum = '0;
      for (int c = 0; c < NUM_CH; c++) w_sum = w_sum + SUM_W'(w_prod_q[c]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sum     <= '0;
         r_t_valid <= 1'b0;
         r_t_last  <= 1'b0;
      end else if (w_adv) begin
         r_sum     <= w_sum;
         r_t_valid <= r_m_valid[MUL_STAGES-1];
         r_t_last  <= r_m_last[MUL_STAGES-1];
      end
   end

   assign w_acc_base = r_first ? '0 : r_acc;
   assign w_acc_n    = w_acc_base + ACC_W'(r_sum);

   das_sat_round #(
      .IN_W  (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_sat_round (
      .i_acc   (w_acc_n),
      .o_dout  (w_dout),
      .o_clamp (w_clamp)
   );

   // Bubbles leave acc/first alone, so a window may span idle cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_first   <= 1'b1;
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
      end else if (w_adv) begin
         out_valid <= r_t_valid & r_t_last;
         if (r_t_valid) begin
            r_acc   <= w_acc_n;
            r_first <= r_t_last;
            if (r_t_last) begin
               dout <= w_dout;
               if (w_clamp) ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_das_mac_pipe.sv
// tb/tb_das_mac_pipe.sv - scoreboard bench for das_mac_pipe with directed vectors
module tb_das_mac_pipe;

   localparam int NUM_CH = 4;
   localparam int DIN_W  = 16;
   localparam int COEF_W = 11;
   localparam int OUT_W  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset, ce, in_valid, in_ready, in_last;
   logic                     out_valid, out_ready, ovf;
   logic [NUM_CH*DIN_W-1:0]  din;
   logic [NUM_CH*COEF_W-1:0] coef;
   logic [OUT_W-1:0]         dout;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   logic signed [OUT_W-1:0] sb_q[$];

   das_mac_pipe #(
      .NUM_CH(NUM_CH), .DIN_W(DIN_W), .COEF_W(COEF_W), .MUL_STAGES(2),
      .ACC_GUARD(8), .SHIFT(10), .OUT_W(OUT_W)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .coef(coef), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .dout(dout), .ovf(ovf)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every output handshake pops the oldest expected result.
   always @(negedge clk) begin
      if (!reset && ce && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d expected none", $signed(dout));
         end else begin
            check("dout", $signed(dout), sb_q.pop_front());
         end
      end
   end

   function automatic logic [NUM_CH*DIN_W-1:0] all_d(input int v);
      logic [NUM_CH*DIN_W-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c*DIN_W +: DIN_W] = DIN_W'(v);
      return r;
   endfunction

   function automatic logic [NUM_CH*COEF_W-1:0] all_c(input int v);
      logic [NUM_CH*COEF_W-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c*COEF_W +: COEF_W] = COEF_W'(v);
      return r;
   endfunction

   function automatic logic [NUM_CH*DIN_W-1:0] one_d(input int v);
      logic [NUM_CH*DIN_W-1:0] r;
      r = '0;
      r[DIN_W-1:0] = DIN_W'(v);
      return r;
   endfunction

   function automatic logic [NUM_CH*COEF_W-1:0] one_c(input int v);
      logic [NUM_CH*COEF_W-1:0] r;
      r = '0;
      r[COEF_W-1:0] = COEF_W'(v);
      return r;
   endfunction

   task automatic send(input logic [NUM_CH*DIN_W-1:0] d, input logic [NUM_CH*COEF_W-1:0] c,
                       input logic last);
      int n;
      @(negedge clk);
      din = d; coef = c; in_last = last; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", 1, 0);
      acc_cyc = cyc;
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sb_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_seen", out_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   initial begin
      bit saw_low;
      reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      din = '0; coef = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_dout", $signed(dout), 0);
      check("rst_ovf", ovf, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      // 1: latency and basic sum
      sb_q.push_back(16'sd2048);
      send(all_d(1024), all_c(512), 1'b1);
      wait_valid();
      check("latency", cyc - acc_cyc, 5);
      drain();
      check("ovf_clear", ovf, 0);

      // 2: rounding of negative and positive halves
      sb_q.push_back(-16'sd1);
      send(one_d(3), one_c(-512), 1'b1);
      sb_q.push_back(16'sd2);
      send(one_d(3), one_c(512), 1'b1);
      drain();
      check("ovf_after_round", ovf, 0);

      // 3: saturation both ways
      sb_q.push_back(16'sd32767);
      send(all_d(32767), all_c(1023), 1'b1);
      sb_q.push_back(-16'sd32768);
      send(all_d(-32768), all_c(1023), 1'b1);
      drain();
      check("ovf_sticky", ovf, 1);

      // 4: 3-beat window with a bubble
      sb_q.push_back(16'sd586);
      send(one_d(1000), one_c(100), 1'b0);
      repeat (3) @(negedge clk);
      send(one_d(1000), one_c(200), 1'b0);
      send(one_d(1000), one_c(300), 1'b1);
      drain();

      // 5: back-pressure with four single-beat windows
      @(negedge clk);
      out_ready = 1'b0;
      saw_low = 1'b0;
      fork
         begin
            for (int k = 1; k <= 4; k++) begin
               sb_q.push_back(16'(1024 * k));
               send(one_d(2048 * k), one_c(512), 1'b1);
            end
         end
         begin
            repeat (10) @(posedge clk);
            #2 out_ready = 1'b1;
         end
         begin
            repeat (12) begin
               @(negedge clk);
               if (!in_ready) saw_low = 1'b1;
            end
         end
      join
      check("in_ready_dropped", saw_low, 1);
      drain();

      // ce=0 freezes a held result
      out_ready = 1'b0;
      sb_q.push_back(16'sd2048);
      send(all_d(1024), all_c(512), 1'b1);
      wait_valid();
      @(negedge clk);
      ce = 1'b0;
      out_ready = 1'b1;
      #1 check("ce0_in_ready", in_ready, 0);
      repeat (5) @(negedge clk);
      check("ce0_hold_valid", out_valid, 1);
      check("ce0_hold_dout", $signed(dout), 2048);
      ce = 1'b1;
      drain();

      // 6: reset mid-window discards the partial sum
      send(one_d(1000), one_c(100), 1'b0);
      send(one_d(1000), one_c(200), 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_dout", $signed(dout), 0);
      check("mid_rst_ovf", ovf, 0);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", in_ready, 1);
      sb_q.push_back(16'sd1024);
      send(one_d(2048), one_c(512), 1'b1);
      drain();
      repeat (10) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
